// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - 8x8 minesweeper mine bitmap builder
//
// Purpose: builds a 64-cell mine bitmap holding exactly the effective mine
// count at pseudo-random positions taken from a 16-bit Galois LFSR. After
// MAX_RETRY consecutive collisions it switches to linear probing, so every
// placement finishes in bounded time. The first-click cell never gets a mine.
//
// Optional feature: define SAFE_ZONE_EN to also keep the in-board
// 8-neighbours of safe_idx free of mines.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        one-cycle build request, sampled only in IDLE
//   mine_count   requested mines 0..64, saturated to the free cell count
//   safe_idx     first-click cell, row*8+col
//   seed_load    loads seed into the LFSR (IDLE only; zero -> DEFAULT_SEED)
//   seed         LFSR seed value
//   board        mine bitmap, bit i = cell i
//   placed       mines placed so far
//   busy         high while clearing or placing
//   done         one-cycle pulse when the board is complete

module mine_placer #(
  parameter int unsigned MAX_RETRY    = 8,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  mine_count,
  input  logic [5:0]  safe_idx,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [63:0] board,
  output logic [6:0]  placed,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PLACE, S_DONE} state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          RW        = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  // Cells that may never hold a mine for a given first-click cell.
  function automatic logic [63:0] excl_mask_f(input logic [5:0] idx);
    logic [63:0] m;
`ifdef SAFE_ZONE_EN
    int r;
    int c;
`endif
    m = '0;
`ifdef SAFE_ZONE_EN
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = int'(idx[5:3]) + dr;
        c = int'(idx[2:0]) + dc;
        if (r >= 0 && r <= 7 && c >= 0 && c <= 7) m[6'(r * 8 + c)] = 1'b1;
      end
    end
`else
    m[idx] = 1'b1;
`endif
    return m;
  endfunction

  state_e        state_q, state_d;
  logic [63:0]   board_q, board_d;
  logic [63:0]   excl_q, excl_d;
  logic [6:0]    placed_q, placed_d;
  logic [6:0]    eff_q, eff_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          probe_q, probe_d;
  logic [5:0]    ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [63:0]   start_excl;
  logic [6:0]    limit;
  logic [6:0]    eff_start;
  logic [15:0]   lfsr_step;
  logic [5:0]    cand;
  logic          collide;
  logic [RW-1:0] retry_nxt;

  always_comb begin
    start_excl = excl_mask_f(safe_idx);
    limit      = 7'd64 - 7'($countones(start_excl));
    eff_start  = (mine_count > limit) ? limit : mine_count;
    lfsr_step  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    cand       = probe_q ? ptr_q : lfsr_q[5:0];
    collide    = board_q[cand] | excl_q[cand];
    retry_nxt  = retry_q + 1'b1;

    state_d  = state_q;
    board_d  = board_q;
    excl_d   = excl_q;
    placed_d = placed_q;
    eff_d    = eff_q;
    lfsr_d   = lfsr_q;
    retry_d  = retry_q;
    probe_d  = probe_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // Seed is loaded in the same cycle as start, so that run uses it.
        if (seed_load) lfsr_d = (seed == 16'h0000) ? DEFAULT_SEED : seed;
        if (start) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          eff_d   = eff_start;
          excl_d  = start_excl;
        end
      end
      S_CLEAR: begin
        board_d  = '0;
        placed_d = '0;
        retry_d  = '0;
        probe_d  = 1'b0;
        if (eff_q == 7'd0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_PLACE;
        end
      end
      S_PLACE: begin
        lfsr_d = lfsr_step;
        if (collide) begin
          if (probe_q) begin
            ptr_d = ptr_q + 6'd1;
          end else begin
            retry_d = retry_nxt;
            if (retry_nxt == RW'(MAX_RETRY)) begin
              probe_d = 1'b1;
              ptr_d   = cand + 6'd1;
            end
          end
        end else begin
          board_d[cand] = 1'b1;
          placed_d      = placed_q + 7'd1;
          retry_d       = '0;
          probe_d       = 1'b0;
          if (placed_q + 7'd1 == eff_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      board_q  <= '0;
      excl_q   <= '0;
      placed_q <= '0;
      eff_q    <= '0;
      lfsr_q   <= DEFAULT_SEED;
      retry_q  <= '0;
      probe_q  <= 1'b0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      excl_q   <= excl_d;
      placed_q <= placed_d;
      eff_q    <= eff_d;
      lfsr_q   <= lfsr_d;
      retry_q  <= retry_d;
      probe_q  <= probe_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign board  = board_q;
  assign placed = placed_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
- Builds an 8x8 minesweeper mine bitmap holding exactly a requested number of mines at pseudo-random positions. It is the write-side counterpart of the board population counter.
- Sits between the game-control FSM, which supplies the count and the first-click cell, and the board register file.
- The placement result always satisfies popcount(board) == effective mine count.

Parameters:
- MAX_RETRY, 8: number of consecutive LFSR collisions tolerated before switching to linear probing.
- DEFAULT_SEED, 16'hACE1: LFSR value used at reset and whenever a zero seed is loaded.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to build a new board; sampled only in IDLE.
- mine_count  in  7  requested number of mines, 0..64; saturated as described in Behaviour.
- safe_idx  in  6  first-click cell (row*8+col); never receives a mine.
- seed_load  in  1  loads the seed into the LFSR; honoured only in IDLE.
- seed  in  16  LFSR seed value.
- board  out  64  mine bitmap, bit i = cell i; held stable outside CLEAR/PLACE.
- placed  out  7  mines placed so far.
- busy  out  1  high in CLEAR and PLACE.
- done  out  1  one-cycle pulse when the board is complete.

Behaviour:
- Reset (async, rst_n=0): board=0, placed=0, busy=0, done=0, state=IDLE, lfsr=DEFAULT_SEED. Reset mid-operation aborts immediately; no partial board survives.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances once per cycle while in PLACE; otherwise holds.
  - seed_load in IDLE loads seed, or DEFAULT_SEED if seed==0.
  - If seed_load and start arrive in the same cycle, the seed is loaded first and used for that run.
- Candidate index: cand = lfsr[5:0] in random mode; in probe mode, cand = probe pointer.
- Effective count: eff = min(mine_count, 64 - excl).
  - excl = 1 without the optional feature.
  - eff is latched at start; later changes to mine_count or safe_idx have no effect on the run in progress.
- States:
  - IDLE: busy=0. On start go to CLEAR. start while busy is ignored.
  - CLEAR (1 cycle): board<=0, placed<=0, retry counter<=0, probe mode off. If eff==0 go to DONE, else go to PLACE.
  - PLACE (one candidate per cycle):
    - Collision: board[cand]=1 or cand is an excluded cell. No write is made; the retry counter increments. When the retry counter reaches MAX_RETRY, enter probe mode with pointer = cand+1 mod 64, wrapping 63->0.
    - Free cell: board[cand]<=1, placed<=placed+1, retry counter<=0, exit probe mode.
    - Probe pointer: in probe mode, a collision advances the pointer by 1 mod 64.
    - Completion: when placed+1==eff on a successful write, go to DONE.
  - DONE (1 cycle): done=1, busy=0, then return to IDLE. board and placed hold until the next start.
- Termination: probe mode bounds each placement to MAX_RETRY+64 cycles, because eff never exceeds the number of free cells.
- Arithmetic: placed and eff are 7-bit, so 64 is representable. The mine_count saturation compare is done in 7 bits.

Optional Feature:
- Macro: SAFE_ZONE_EN.
- Defined: the excluded set is safe_idx plus its in-board 8-neighbours (row/col clipped at the 0 and 7 edges).
  - excl = 4 at a corner, 6 on an edge, 9 in the interior.
  - All excluded cells are 0 in every output board.
- Undefined: only safe_idx is excluded, excl=1, and the maximum eff is 63.

Test Plan:
- Reset mid-PLACE: seed 16'h1234, mine_count=10, safe_idx=27; assert rst_n=0 at cycle 5 -> board=0, placed=0, busy=0 immediately, and state is IDLE after release.
- Basic run: seed 16'h1234, mine_count=10, safe_idx=0 -> done pulses once, popcount(board)=10, board[0]=0, placed=10, busy falls in the same cycle done rises.
- Zero and saturation:
  - mine_count=0 -> done exactly 2 cycles after start, board=0.
  - mine_count=64 without SAFE_ZONE_EN -> popcount(board)=63, board[safe_idx]=0.
- Probe fallback: MAX_RETRY=2, mine_count=63 -> completes within 63*(2+64)+3 cycles and board == ~(64'b1<<safe_idx).
- SAFE_ZONE_EN with safe_idx=0 and mine_count=64 -> popcount=60, bits 0,1,8,9 clear. With safe_idx=27 -> popcount=55, bits 18-20, 26-28, 34-36 clear.
- Ignored inputs: start pulsed during busy, and seed_load during PLACE -> no restart, LFSR sequence unchanged. The same seed replayed gives a bit-identical board.
